// File: rtl/apb_req_arbiter.sv
// ----------------------------------------------------------------------------
// apb_req_arbiter
// Shares one APB bus among NREQ local requesters. Commands are accepted
// round-robin through a valid/ready handshake, executed as a fixed
// SETUP/ACCESS transfer (no wait states, no error response) and completed
// with a one-cycle done pulse plus read data.
//
// Ports
//   PCLK, PRST          clock, asynchronous active-high reset
//   req_valid/req_write per-requester command present / direction
//   req_addr/req_wdata  per-requester address and write data, packed i*W +: W
//   req_ready           one-hot combinational acceptance
//   rsp_done            one-hot registered completion pulse
//   rsp_rdata           data of the most recently completed read
//   PSEL..PWDATA,PRDATA APB master signals
//   busy                transfer in progress (SETUP or ACCESS)
// ----------------------------------------------------------------------------
module apb_req_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 32,
    parameter int DW   = 32
) (
    input  logic              PCLK,
    input  logic              PRST,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ-1:0]   req_write,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   rsp_done,
    output logic [DW-1:0]     rsp_rdata,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [AW-1:0]     PADDR,
    output logic [DW-1:0]     PWDATA,
    input  logic [DW-1:0]     PRDATA,
    output logic              busy
);

    // state  | meaning
    // IDLE   | bus quiet, arbitrating
    // SETUP  | first APB phase, PSEL only
    // ACCESS | second APB phase, completes at its closing edge, arbitrating

    localparam int IDW  = $clog2(NREQ);
    localparam int IDW1 = IDW + 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [IDW-1:0] last_id;
    logic [IDW-1:0] cur_id;
    logic [IDW-1:0] win_id;
    logic           win_found;
    logic           accept;
    logic [IDW:0]   cand_sum;
    logic [IDW-1:0] cand;

    // Round-robin search starting just after the last winner; the extra sum
    // bit lets the wrap work for NREQ values that are not a power of two.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand_sum  = '0;
        cand      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand_sum = {1'b0, last_id} + IDW1'(k);
            if (cand_sum >= IDW1'(NREQ))
                cand_sum = cand_sum - IDW1'(NREQ);
            cand = cand_sum[IDW-1:0];
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    assign accept    = win_found && (state == ST_IDLE || state == ST_ACCESS);
    assign req_ready = accept ? (NREQ'(1) << win_id) : '0;

    always_comb begin
        state_nxt = state;
        PSEL      = 1'b0;
        PENABLE   = 1'b0;
        busy      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (win_found)
                    state_nxt = ST_SETUP;
            end
            ST_SETUP: begin
                PSEL      = 1'b1;
                busy      = 1'b1;
                state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                PSEL      = 1'b1;
                PENABLE   = 1'b1;
                busy      = 1'b1;
                state_nxt = win_found ? ST_SETUP : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRST) begin
        if (PRST) begin
            state     <= ST_IDLE;
            last_id   <= IDW'(NREQ - 1);
            cur_id    <= '0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            rsp_done  <= '0;
            rsp_rdata <= '0;
        end else begin
            state    <= state_nxt;
            rsp_done <= '0;
            // Completion uses the old PWRITE/cur_id even when a new command
            // is accepted on this same edge.
            if (state == ST_ACCESS) begin
                rsp_done <= NREQ'(1) << cur_id;
                if (!PWRITE)
                    rsp_rdata <= PRDATA;
            end
            if (accept) begin
                cur_id  <= win_id;
                last_id <= win_id;
                PWRITE  <= req_write[win_id];
                PADDR   <= req_addr[win_id*AW +: AW];
                PWDATA  <= req_wdata[win_id*DW +: DW];
            end
        end
    end

endmodule

// File: tb/tb_apb_req_arbiter.sv
module tb_apb_req_arbiter;
    localparam int NREQ = 4;
    localparam int AW   = 32;
    localparam int DW   = 32;

    logic               PCLK = 1'b0;
    logic               PRST;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_write;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    rsp_done;
    logic [DW-1:0]      rsp_rdata;
    logic               PSEL;
    logic               PENABLE;
    logic               PWRITE;
    logic [AW-1:0]      PADDR;
    logic [DW-1:0]      PWDATA;
    logic [DW-1:0]      PRDATA;
    logic               busy;

    apb_req_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .PCLK      (PCLK),
        .PRST      (PRST),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_done  (rsp_done),
        .rsp_rdata (rsp_rdata),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .busy      (busy)
    );

    always #5 PCLK = ~PCLK;

    // APB slave memory, word addressed by PADDR[9:2], zero wait states
    logic [31:0] mem [0:255] = '{default: '0};
    always @(posedge PCLK)
        if (PSEL && PENABLE && PWRITE)
            mem[PADDR[9:2]] <= PWDATA;
    assign PRDATA = mem[PADDR[9:2]];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [NREQ-1:0] oh(input int i);
        logic [NREQ-1:0] r;
        r    = '0;
        r[i] = 1'b1;
        return r;
    endfunction

    task automatic drive(input int i, input bit w, input logic [31:0] a, input logic [31:0] d);
        req_write[i]         = w;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
        req_valid[i]         = 1'b1;
    endtask

    function automatic logic [31:0] eng_addr(input int i, input int k);
        return 32'(32'h100 + i * 64 + k * 4);
    endfunction

    function automatic logic [31:0] eng_data(input int i, input int k);
        return 32'(32'hC000_0000 + i * 256 + k);
    endfunction

    function automatic logic [31:0] mem_at(input logic [31:0] a);
        logic [7:0] idx;
        idx = a[9:2];
        return mem[idx];
    endfunction

    typedef struct {
        int          id;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[7];

    // single isolated transfer from IDLE, called at posedge+1
    task automatic single(input vec_t v);
        drive(v.id, v.wr, v.addr, v.wdata);
        @(negedge PCLK);
        chk("c0_ready", req_ready, oh(v.id));
        chk("c0_psel", PSEL, 0);
        @(posedge PCLK); #1;
        req_valid[v.id] = 1'b0;
        @(negedge PCLK);
        chk("c1_psel", PSEL, 1);
        chk("c1_penable", PENABLE, 0);
        chk("c1_pwrite", PWRITE, v.wr);
        chk("c1_paddr", PADDR, v.addr);
        chk("c1_busy", busy, 1);
        if (v.wr) chk("c1_pwdata", PWDATA, v.wdata);
        @(negedge PCLK);
        chk("c2_psel", PSEL, 1);
        chk("c2_penable", PENABLE, 1);
        chk("c2_paddr", PADDR, v.addr);
        chk("c2_done", rsp_done, 0);
        @(negedge PCLK);
        chk("c3_done", rsp_done, oh(v.id));
        chk("c3_rdata", rsp_rdata, v.exp_rdata);
        chk("c3_psel", PSEL, 0);
        chk("c3_busy", busy, 0);
        if (v.wr) chk("c3_mem", mem_at(v.addr), v.wdata);
        @(posedge PCLK); #1;
    endtask

    int left[NREQ];
    int nxt[NREQ];
    int grant_q[$];
    int done_q[$];
    int done_cyc_q[$];
    int exp_q[$];
    int psel_cnt, psel_first, psel_last;

    task automatic prime();
        for (int i = 0; i < NREQ; i++)
            if (left[i] > 0) drive(i, 1'b1, eng_addr(i, nxt[i]), eng_data(i, nxt[i]));
    endtask

    // Requesters re-present their next command the cycle after ready.
    task automatic run(input int ncmd, input int max_cyc);
        bit acc[NREQ];
        grant_q.delete();
        done_q.delete();
        done_cyc_q.delete();
        psel_cnt   = 0;
        psel_first = -1;
        psel_last  = -1;
        for (int c = 0; c < max_cyc && done_q.size() < ncmd; c++) begin
            @(negedge PCLK);
            if (PSEL) begin
                psel_cnt++;
                if (psel_first < 0) psel_first = c;
                psel_last = c;
            end
            if (rsp_done != '0) begin
                chk("done_onehot", $countones(rsp_done), 1);
                for (int i = 0; i < NREQ; i++)
                    if (rsp_done[i]) begin
                        done_q.push_back(i);
                        done_cyc_q.push_back(c);
                    end
            end
            for (int i = 0; i < NREQ; i++) begin
                acc[i] = req_ready[i];
                if (acc[i]) grant_q.push_back(i);
            end
            @(posedge PCLK); #1;
            for (int i = 0; i < NREQ; i++)
                if (acc[i]) begin
                    nxt[i]++;
                    left[i]--;
                    if (left[i] > 0) drive(i, 1'b1, eng_addr(i, nxt[i]), eng_data(i, nxt[i]));
                    else req_valid[i] = 1'b0;
                end
        end
        chk("run_done_count", done_q.size(), ncmd);
        chk("run_grant_count", grant_q.size(), ncmd);
        for (int k = 0; k < ncmd; k++) begin
            if (k < grant_q.size()) chk($sformatf("grant_%0d", k), grant_q[k], exp_q[k]);
            if (k < done_q.size())  chk($sformatf("done_id_%0d", k), done_q[k], exp_q[k]);
            if (k > 0 && k < done_cyc_q.size())
                chk($sformatf("done_gap_%0d", k), done_cyc_q[k] - done_cyc_q[k-1], 2);
        end
        chk("psel_cycles", psel_cnt, 2 * ncmd);
        chk("psel_contig", psel_last - psel_first + 1, 2 * ncmd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{id: 0, wr: 1'b1, addr: 32'h10, wdata: 32'hA5A5_0001, exp_rdata: 32'h0};
        vecs[1] = '{id: 2, wr: 1'b0, addr: 32'h10, wdata: 32'h0,         exp_rdata: 32'hA5A5_0001};
        vecs[2] = '{id: 1, wr: 1'b1, addr: 32'h14, wdata: 32'h1234_5678, exp_rdata: 32'hA5A5_0001};
        vecs[3] = '{id: 3, wr: 1'b0, addr: 32'h14, wdata: 32'h0,         exp_rdata: 32'h1234_5678};
        vecs[4] = '{id: 3, wr: 1'b1, addr: 32'h10, wdata: 32'hDEAD_BEEF, exp_rdata: 32'h1234_5678};
        vecs[5] = '{id: 0, wr: 1'b0, addr: 32'h10, wdata: 32'h0,         exp_rdata: 32'hDEAD_BEEF};
        vecs[6] = '{id: 1, wr: 1'b0, addr: 32'h3C, wdata: 32'h0,         exp_rdata: 32'h0};

        PRST      = 1'b1;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        chk("rst_psel", PSEL, 0);
        chk("rst_penable", PENABLE, 0);
        chk("rst_pwrite", PWRITE, 0);
        chk("rst_paddr", PADDR, 0);
        chk("rst_pwdata", PWDATA, 0);
        chk("rst_done", rsp_done, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_busy", busy, 0);
        @(posedge PCLK); #1;
        PRST = 1'b0;
        @(negedge PCLK);
        chk("idle_psel", PSEL, 0);
        chk("idle_ready", req_ready, 0);
        @(posedge PCLK); #1;

        for (int v = 0; v < 7; v++) single(vecs[v]);

        // same requester, write then read, second accepted in ACCESS
        drive(2, 1'b1, 32'h40, 32'h55AA_0002);
        @(negedge PCLK);
        chk("b2b_c0_ready", req_ready, 4'b0100);
        @(posedge PCLK); #1;
        drive(2, 1'b0, 32'h40, 32'h0);
        @(negedge PCLK);
        chk("b2b_c1_setup_noready", req_ready, 0);
        chk("b2b_c1_pwrite", PWRITE, 1);
        chk("b2b_c1_penable", PENABLE, 0);
        @(negedge PCLK);
        chk("b2b_c2_penable", PENABLE, 1);
        chk("b2b_c2_ready", req_ready, 4'b0100);
        @(posedge PCLK); #1;
        req_valid[2] = 1'b0;
        @(negedge PCLK);
        chk("b2b_c3_done", rsp_done, 4'b0100);
        chk("b2b_c3_psel", PSEL, 1);
        chk("b2b_c3_penable", PENABLE, 0);
        chk("b2b_c3_pwrite", PWRITE, 0);
        chk("b2b_c3_mem", mem_at(32'h40), 32'h55AA_0002);
        @(negedge PCLK);
        chk("b2b_c4_done", rsp_done, 0);
        chk("b2b_c4_penable", PENABLE, 1);
        @(negedge PCLK);
        chk("b2b_c5_done", rsp_done, 4'b0100);
        chk("b2b_c5_rdata", rsp_rdata, 32'h55AA_0002);
        @(posedge PCLK); #1;

        // reset during ACCESS of a write to 0x20
        drive(1, 1'b1, 32'h20, 32'h0000_0077);
        @(negedge PCLK);
        chk("rmt_c0_ready", req_ready, 4'b0010);
        @(posedge PCLK); #1;
        req_valid[1] = 1'b0;
        @(negedge PCLK);
        @(negedge PCLK);
        chk("rmt_access", PENABLE, 1);
        PRST = 1'b1;
        #1;
        chk("rmt_psel", PSEL, 0);
        chk("rmt_penable", PENABLE, 0);
        chk("rmt_pwrite", PWRITE, 0);
        chk("rmt_paddr", PADDR, 0);
        chk("rmt_pwdata", PWDATA, 0);
        chk("rmt_busy", busy, 0);
        chk("rmt_rdata", rsp_rdata, 0);
        @(posedge PCLK); #1;
        chk("rmt_done", rsp_done, 0);
        chk("rmt_mem", mem_at(32'h20), 0);

        // contention from reset: grant order reveals last_id back at NREQ-1
        for (int i = 0; i < NREQ; i++) begin
            left[i] = 1;
            nxt[i]  = 0;
        end
        exp_q = '{0, 1, 2, 3};
        prime();
        PRST = 1'b0;
        run(4, 40);

        // fairness: 1 and 3 continuously valid, 8 commands each
        for (int i = 0; i < NREQ; i++) begin
            left[i] = (i == 1 || i == 3) ? 8 : 0;
            nxt[i]  = 0;
        end
        exp_q.delete();
        for (int k = 0; k < 16; k++) exp_q.push_back((k % 2 == 0) ? 1 : 3);
        prime();
        run(16, 100);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("fair_mem1_%0d", k), mem_at(eng_addr(1, k)), eng_data(1, k));
            chk($sformatf("fair_mem3_%0d", k), mem_at(eng_addr(3, k)), eng_data(3, k));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
